sync_rx_frame_ctrl: RTL and testbench
=====================================

Name: sync_rx_frame_ctrl

Overview:
Frame controller for the synchronous serial receive path. It synchronises the external data_clk, data_point and Enable into the clk domain, detects data_clk rising edges, and shifts in fixed-length MSB-first frames. Each completed frame is presented with a one-cycle valid strobe for the display/value stage. Enable drop-out and clock stalls are reported as framing errors.

Parameters:
FRAME_BITS, 8, data bits per frame; legal range 2..32.
TIMEOUT, 64, clk cycles allowed between data_clk rising edges inside a frame; minimum 8.
CNT_W, 8, width of the good-frame counter.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
data_clk  input  1  external serial clock, asynchronous to clk
data_point  input  1  serial data, sampled on data_clk rising edge
Enable  input  1  external receive enable, active-high
frame_data  output  FRAME_BITS  last good frame, MSB = first bit received
frame_valid  output  1  one-cycle pulse when frame_data updates
busy  output  1  high while a frame is in progress (SHIFT state)
frame_err  output  1  one-cycle pulse on a framing error
frame_count  output  CNT_W  count of good frames, wraps modulo 2^CNT_W

Behaviour:
- Design has one clock and one reset. Reset is asynchronous and active-low.
- Reset values: all synchronisers 0; state IDLE; shift register, bit_cnt and timer 0; frame_data 0; frame_valid, frame_err and busy 0; frame_count 0.
- Synchronisation:
  - data_clk, data_point and Enable each pass through a 2-flop synchroniser (s1, s2). data_clk has a third flop, s3.
  - dclk_rise = dclk_s2 & ~dclk_s3. The sampled bit is dp_s2; the effective enable is en_s2.
  - A data_clk rise is acted on 3 clk edges after the pin edge.
- Input requirement: data_clk high time and low time are each at least 2 clk periods. Guaranteed edge spacing is therefore at least 4 clk cycles.
- IDLE:
  - busy = 0.
  - On dclk_rise & en_s2: shreg <= {.., dp_s2}, bit_cnt <= 1, timer <= 0, go to SHIFT.
  - dclk_rise with en_s2 = 0 is ignored.
- SHIFT:
  - busy = 1. timer increments every cycle and clears on each dclk_rise.
  - On dclk_rise & en_s2: shift in dp_s2 and increment bit_cnt. When the incremented bit_cnt equals the total frame length, go to DONE.
  - If en_s2 == 0, go to ERR. This takes priority over a simultaneous dclk_rise.
  - If timer reaches TIMEOUT-1 without dclk_rise, go to ERR.
- DONE (one cycle):
  - frame_data <= shreg and frame_valid = 1 that cycle.
  - frame_count increments; it wraps from 2^CNT_W-1 to 0.
  - Next state is IDLE. If dclk_rise & en_s2 also occurs this cycle, it is taken as bit 1 of the next frame and the next state is SHIFT.
- ERR (one cycle):
  - frame_err = 1; shreg and bit_cnt are cleared; next state is IDLE.
  - frame_data and frame_count are unchanged.
- frame_valid and frame_err are registered state-decoded pulses and are never high together.
- Reset asserted mid-frame: immediate return to reset values. A partial frame is discarded with no pulse.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - Total frame length is FRAME_BITS+1; the final bit is an even-parity bit.
  - At the last bit, if XOR(data bits, parity bit) = 1, go to ERR instead of DONE: frame_err pulses, frame_data is not updated, and frame_count is not incremented.
  - The parity bit is never stored in frame_data.
- Undefined: total frame length is FRAME_BITS and there is no parity logic.

Test Plan:
- Reset: hold rst=0 with data_clk toggling -> all outputs 0. Release rst, Enable=0, 8 data_clk rises -> frame_valid never pulses and busy stays 0.
- Good frame: clk 10ns, data_clk 40ns period, Enable=1, send bits 1,0,1,0,0,1,0,1 -> exactly one frame_valid pulse, frame_data=8'hA5, frame_count=1. frame_valid pulses 4 clk cycles after the 8th data_clk rise (3 synchroniser edges + DONE).
- Enable drop: Enable=1, send 3 bits, then Enable=0 for 80ns -> one frame_err pulse, busy falls, frame_data keeps its previous value. Re-enable and send 8'h3C -> frame_data=8'h3C.
- Timeout: send 5 bits, then stop data_clk for 70 clk cycles -> frame_err pulses once, 64 cycles after the 5th bit was taken; state returns to IDLE; frame_count unchanged.
- Back-to-back and wrap: 256 consecutive frames of 8'hFF -> 256 frame_valid pulses, frame_count=0 afterwards, no frame_err.
- PARITY_CHECK_EN: 8'hA5 + parity 0 -> frame_valid, frame_data=8'hA5. 8'hA5 + parity 1 -> frame_err, frame_data unchanged.

Source files
------------

// File: rtl/sync_rx_frame_ctrl.sv
// Serial frame receiver: syncs data_clk/data_point/Enable, shifts MSB-first frames, pulses valid/err.
// Latency: frame_valid 4 clk edges after the last data_clk pin rise. No backpressure: pulses are one-shot.
// Optional PARITY_CHECK_EN appends an even-parity bit to each frame and rejects bad parity.
module sync_rx_frame_ctrl #(
    parameter int FRAME_BITS = 8,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_clk,
    input  logic                  data_point,
    input  logic                  Enable,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      frame_count
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = FRAME_BITS + 1;
`else
    localparam int FRAME_LEN = FRAME_BITS;
`endif
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] LAST_CNT = BW'(FRAME_LEN - 1);
    // The timer value whose increment would reach TIMEOUT-1
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic dclk_s1_q, dclk_s2_q, dclk_s3_q;
    logic dp_s1_q, dp_s2_q;
    logic en_s1_q, en_s2_q;

    logic [1:0]            state_q, state_d;
    logic [FRAME_LEN-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [FRAME_BITS-1:0] frame_data_q;
    logic [CNT_W-1:0]      frame_count_q;
    logic                  frame_valid_q, frame_err_q;

    logic dclk_rise, take, parity_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dclk_s1_q <= 1'b0;
            dclk_s2_q <= 1'b0;
            dclk_s3_q <= 1'b0;
            dp_s1_q   <= 1'b0;
            dp_s2_q   <= 1'b0;
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
        end else begin
            dclk_s1_q <= data_clk;
            dclk_s2_q <= dclk_s1_q;
            dclk_s3_q <= dclk_s2_q;
            dp_s1_q   <= data_point;
            dp_s2_q   <= dp_s1_q;
            en_s1_q   <= Enable;
            en_s2_q   <= en_s1_q;
        end
    end

    assign dclk_rise = dclk_s2_q & ~dclk_s3_q;
    assign take      = dclk_rise & en_s2_q;

`ifdef PARITY_CHECK_EN
    assign parity_bad = ^{shreg_q[FRAME_BITS-1:0], dp_s2_q};
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (take) begin
                    shreg_d   = {{(FRAME_LEN-1){1'b0}}, dp_s2_q};
                    bit_cnt_d = BW'(1);
                    timer_d   = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Enable loss wins over a coincident data_clk rise
                if (!en_s2_q) begin
                    state_d = ST_ERR;
                end else if (dclk_rise) begin
                    shreg_d   = {shreg_q[FRAME_LEN-2:0], dp_s2_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    timer_d   = '0;
                    if (bit_cnt_q == LAST_CNT)
                        state_d = parity_bad ? ST_ERR : ST_DONE;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                timer_d   = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            timer_q       <= '0;
            frame_data_q  <= '0;
            frame_count_q <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            timer_q       <= timer_d;
            frame_valid_q <= (state_q == ST_DONE);
            frame_err_q   <= (state_q == ST_ERR);
            if (state_q == ST_DONE) begin
                frame_data_q  <= shreg_q[FRAME_LEN-1 -: FRAME_BITS];
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_count = frame_count_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_sync_rx_frame_ctrl.sv
// Bench for sync_rx_frame_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_sync_rx_frame_ctrl;
    localparam int FB = 8;
`ifdef PARITY_CHECK_EN
    localparam int FLEN = FB + 1;
`else
    localparam int FLEN = FB;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_clk = 1'b0;
    logic          data_point = 1'b0;
    logic          Enable = 1'b0;
    logic [FB-1:0] frame_data;
    logic          frame_valid, busy, frame_err;
    logic [7:0]    frame_count;

    sync_rx_frame_ctrl #(.FRAME_BITS(FB), .TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .data_clk(data_clk), .data_point(data_point), .Enable(Enable),
        .frame_data(frame_data), .frame_valid(frame_valid), .busy(busy),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_valid = 0, n_errp = 0, n_busy = 0, n_both = 0;
    int last_valid_cyc = 0, last_err_cyc = 0, rise_cyc = 0;
    int n_chk = 0, n_err = 0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (frame_valid) begin n_valid = n_valid + 1; last_valid_cyc = cyc; end
        if (frame_err)   begin n_errp = n_errp + 1;   last_err_cyc = cyc;   end
        if (busy) n_busy = n_busy + 1;
        if (frame_valid && frame_err) n_both = n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        data_point = b;
        @(negedge clk);
        data_clk = 1'b1;
        rise_cyc = cyc;
        wait_neg(hi);
        data_clk = 1'b0;
        wait_neg(lo);
    endtask

    // Sends the first nbits of a frame (data MSB first, then parity when enabled)
    task automatic send_frame(input logic [FB-1:0] d, input int nbits, input bit rnd, input bit flip_par);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = (i < FB) ? d[FB-1-i] : ((^d) ^ flip_par);
            if (rnd) send_bit(b, $urandom_range(2, 4), $urandom_range(2, 5));
            else     send_bit(b, 2, 2);
        end
    endtask

    logic [FB-1:0] exp_data;
    logic [7:0]    exp_count;
    int v0, e0, b0, drop_cyc;

    initial begin
        // Reset held while data_clk toggles
        send_frame(8'hFF, 4, 1'b0, 1'b0);
        check("rst_data", 32'(frame_data), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(frame_count), 32'h0);

        rst = 1'b1;
        wait_neg(3);
        v0 = n_valid; b0 = n_busy;
        send_frame(8'hA5, FLEN, 1'b0, 1'b0);
        wait_neg(8);
        check("disabled_valid", 32'(n_valid - v0), 32'h0);
        check("disabled_busy", 32'(n_busy - b0), 32'h0);

        // Good frame and its latency
        Enable = 1'b1;
        wait_neg(3);
        v0 = n_valid; e0 = n_errp;
        send_frame(8'hA5, FLEN, 1'b0, 1'b0);
        wait_neg(6);
        check("good_pulses", 32'(n_valid - v0), 32'h1);
        check("good_data", 32'(frame_data), 32'hA5);
        check("good_count", 32'(frame_count), 32'h1);
        check("good_latency", 32'(last_valid_cyc - rise_cyc), 32'd4);
        check("good_noerr", 32'(n_errp - e0), 32'h0);
        exp_data = 8'hA5; exp_count = 8'h1;

        // Enable drop mid-frame
        e0 = n_errp; v0 = n_valid;
        send_frame(8'hE0, 3, 1'b0, 1'b0);
        check("drop_busy_before", 32'(busy), 32'h1);
        Enable = 1'b0;
        drop_cyc = cyc;
        wait_neg(8);
        check("drop_err", 32'(n_errp - e0), 32'h1);
        check("drop_err_latency", 32'(last_err_cyc - drop_cyc), 32'd4);
        check("drop_busy", 32'(busy), 32'h0);
        check("drop_data", 32'(frame_data), 32'(exp_data));
        check("drop_novalid", 32'(n_valid - v0), 32'h0);
        Enable = 1'b1;
        wait_neg(3);
        send_frame(8'h3C, FLEN, 1'b0, 1'b0);
        wait_neg(6);
        check("reenable_data", 32'(frame_data), 32'h3C);
        check("reenable_count", 32'(frame_count), 32'h2);
        exp_data = 8'h3C; exp_count = 8'h2;

        // data_clk stall
        e0 = n_errp;
        send_frame(8'h5A, 5, 1'b0, 1'b0);
        wait_neg(70);
        check("timeout_err", 32'(n_errp - e0), 32'h1);
        check("timeout_latency", 32'(last_err_cyc - rise_cyc), 32'd67);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_count", 32'(frame_count), 32'(exp_count));
        check("timeout_data", 32'(frame_data), 32'(exp_data));

`ifdef PARITY_CHECK_EN
        v0 = n_valid; e0 = n_errp;
        send_frame(8'hA5, FLEN, 1'b0, 1'b0);
        wait_neg(6);
        check("par_ok_valid", 32'(n_valid - v0), 32'h1);
        check("par_ok_data", 32'(frame_data), 32'hA5);
        exp_data = 8'hA5; exp_count = exp_count + 8'd1;
        e0 = n_errp;
        send_frame(8'h00, FLEN, 1'b0, 1'b1);
        wait_neg(6);
        check("par_bad_err", 32'(n_errp - e0), 32'h1);
        check("par_bad_data", 32'(frame_data), 32'hA5);
        check("par_bad_count", 32'(frame_count), 32'(exp_count));
`endif

        // Randomized frames against the frame-level model
        for (int it = 0; it < 24; it++) begin
            logic [FB-1:0] d;
            bit drop, badp;
            d = FB'($urandom);
            drop = ($urandom_range(0, 3) == 0);
`ifdef PARITY_CHECK_EN
            badp = ($urandom_range(0, 4) == 0);
`else
            badp = 1'b0;
`endif
            v0 = n_valid; e0 = n_errp;
            if (drop) begin
                send_frame(d, $urandom_range(1, FLEN - 1), 1'b1, 1'b0);
                Enable = 1'b0;
                wait_neg(6);
                Enable = 1'b1;
                wait_neg(3);
            end else begin
                send_frame(d, FLEN, 1'b1, badp);
                wait_neg(6);
                if (!badp) begin
                    exp_data = d;
                    exp_count = exp_count + 8'd1;
                end
            end
            check("rnd_valid", 32'(n_valid - v0), (drop || badp) ? 32'h0 : 32'h1);
            check("rnd_err", 32'(n_errp - e0), (drop || badp) ? 32'h1 : 32'h0);
            check("rnd_data", 32'(frame_data), 32'(exp_data));
            check("rnd_count", 32'(frame_count), 32'(exp_count));
        end

        // Reset mid-frame, then 256 back-to-back frames wrap the counter
        send_frame(8'hC3, 3, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_data", 32'(frame_data), 32'h0);
        check("midrst_count", 32'(frame_count), 32'h0);
        wait_neg(2);
        rst = 1'b1;
        wait_neg(3);
        v0 = n_valid; e0 = n_errp;
        for (int f = 0; f < 256; f++) send_frame(8'hFF, FLEN, 1'b0, 1'b0);
        wait_neg(6);
        check("wrap_valid", 32'(n_valid - v0), 32'd256);
        check("wrap_count", 32'(frame_count), 32'h0);
        check("wrap_noerr", 32'(n_errp - e0), 32'h0);
        check("wrap_data", 32'(frame_data), 32'hFF);
        check("never_both", 32'(n_both), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
